// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the load/store path: byte/half/word accesses
// with a fixed wait latency, a combinational Busy stall and one-cycle Done/Err pulses.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WrData,
    output logic [31:0]       RdData,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              store_q, store_d;
    logic              bad_q, bad_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       word;
    logic              req_err;
    logic              commit;
    logic [3:0]        byte_en;
    logic [31:0]       wr_word;
    logic [31:0]       wr_mask;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;

    assign word_idx = addr_q[ADDR_W-1:2];
    assign word     = mem[word_idx];
    assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !req_err;
    assign RdData   = rdata_q;

    // Legality of the captured request; decides both the Err pulse and commit gating.
    always_comb begin
        req_err = 1'b0;
        if (bad_q) begin
            req_err = 1'b1;
        end else begin
            case (funct3_q)
                3'b000:  req_err = 1'b0;
                3'b001:  req_err = addr_q[0];
                3'b010:  req_err = |addr_q[1:0];
                3'b100:  req_err = store_q;
                3'b101:  req_err = store_q | addr_q[0];
                default: req_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        byte_en = 4'b1111;
        wr_word = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        wr_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    end

    always_comb begin
        ld_byte = 8'(word >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? word[31:16] : word[15:0];
        case (funct3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = word;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        bad_d    = bad_q;
        rdata_d  = rdata_q;
        Busy     = 1'b0;
        Done     = 1'b0;
        Err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    Busy     = 1'b1;
                    addr_d   = Addr;
                    funct3_d = Funct3;
                    wdata_d  = WrData;
                    store_d  = MemWrite & ~MemRead;
                    bad_d    = MemRead & MemWrite;
                    cnt_d    = CNT_INIT;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                Busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (commit && !store_q) begin
                        rdata_d = ld_val;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                Done    = 1'b1;
                Err     = req_err;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Requests must not stall the pipeline while the block is held in reset.
        if (reset) begin
            Busy = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            store_q  <= 1'b0;
            bad_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            bad_q    <= bad_d;
            rdata_q  <= rdata_d;
        end
    end

    // NOTE: the storage array is deliberately not reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (commit && store_q) begin
            mem[word_idx] <= (word & ~wr_mask) | (wr_word & wr_mask);
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int LAT    = 2;
    localparam int HOLD_W = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [8:0]  Addr = 9'h0;
    logic [31:0] WrData = 32'h0;

    logic [31:0] RdData, rd1, rd15;
    logic        Busy, Done, Err;
    logic        busy1, done1, err1, busy15, done15, err15;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  ref_mem [512];
    logic [31:0] exp_rd;
    int          q1[$], q2[$], q15[$];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(128), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .Addr(Addr), .WrData(WrData), .RdData(RdData), .Busy(Busy), .Done(Done), .Err(Err)
    );
    data_mem_responder #(.DEPTH(128), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .Addr(Addr), .WrData(WrData), .RdData(rd1), .Busy(busy1), .Done(done1), .Err(err1)
    );
    data_mem_responder #(.DEPTH(128), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .Addr(Addr), .WrData(WrData), .RdData(rd15), .Busy(busy15), .Done(done15), .Err(err15)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rules: access size is 1 << funct3[1:0] bytes and must be size-aligned.
    function automatic logic ref_err(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [8:0] a);
        int size;
        if (rd && wr) return 1'b1;
        if (f3[1:0] == 2'b11 || f3[2:1] == 2'b11) return 1'b1;
        if (wr && f3[2]) return 1'b1;
        size = 1 << f3[1:0];
        return (int'(a) % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [8:0] a);
        int size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    endtask

    // One complete transaction; inputs are scrambled while the block is busy.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] wd);
        int   busy_cnt, cyc;
        logic got_done, got_err, stray_err, e;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
        #1;
        busy_cnt = Busy ? 1 : 0;
        cyc = 0; got_done = 1'b0; got_err = 1'b0; stray_err = 1'b0;
        while (!got_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (Done) begin
                got_done = 1'b1;
                got_err  = Err;
            end else begin
                if (Busy) busy_cnt++;
                if (Err) stray_err = 1'b1;
                MemRead  = 1'($urandom_range(0, 1));
                MemWrite = 1'($urandom_range(0, 1));
                Funct3   = 3'($urandom);
                Addr     = 9'($urandom);
                WrData   = $urandom;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        e = ref_err(rd, wr, f3, a);
        if (!e) begin
            if (wr) ref_store(f3, a, wd);
            else exp_rd = ref_load(f3, a);
        end
        check({tag, ".done_seen"}, 32'(got_done), 32'd1);
        check({tag, ".latency"}, cyc, LAT + 1);
        check({tag, ".busy_cycles"}, busy_cnt, LAT + 1);
        check({tag, ".err"}, 32'(got_err), 32'(e));
        check({tag, ".stray_err"}, 32'(stray_err), 32'd0);
        check({tag, ".rddata"}, RdData, exp_rd);
    endtask

    task automatic check_hold(input string tag, input int lat, input int q[$]);
        int n;
        n = 0;
        while (n * (lat + 2) + lat + 1 < HOLD_W) n++;
        check({tag, ".done_count"}, q.size(), n);
        for (int k = 0; k < q.size() && k < n; k++)
            check($sformatf("%s.done_cycle%0d", tag, k), q[k], k * (lat + 2) + lat + 1);
    endtask

    initial begin
        exp_rd = 32'h0;
        MemRead = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(Busy), 32'd0);
        check("reset.done", 32'(Done), 32'd0);
        check("reset.err", 32'(Err), 32'd0);
        check("reset.rddata", RdData, 32'h0);
        MemRead = 1'b0;
        reset = 1'b0;

        for (int w = 0; w < 128; w++) access("init", 1'b0, 1'b1, 3'b010, 9'(w * 4), $urandom);

        access("sw10", 1'b0, 1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF);
        access("lw10", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
        check("lw10.value", RdData, 32'hDEAD_BEEF);

        access("sb11", 1'b0, 1'b1, 3'b000, 9'h011, 32'h0000_0080);
        access("lb11", 1'b1, 1'b0, 3'b000, 9'h011, 32'h0);
        check("lb11.value", RdData, 32'hFFFF_FF80);
        access("lbu11", 1'b1, 1'b0, 3'b100, 9'h011, 32'h0);
        check("lbu11.value", RdData, 32'h0000_0080);
        access("lh10", 1'b1, 1'b0, 3'b001, 9'h010, 32'h0);
        check("lh10.value", RdData, 32'hFFFF_80EF);
        access("lw10b", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
        check("lw10b.value", RdData, 32'hDEAD_80EF);

        access("lw12_mis", 1'b1, 1'b0, 3'b010, 9'h012, 32'h0);
        check("lw12_mis.unchanged", RdData, 32'hDEAD_80EF);
        access("sh13_mis", 1'b0, 1'b1, 3'b001, 9'h013, 32'hFFFF_FFFF);
        access("both_req", 1'b1, 1'b1, 3'b010, 9'h010, 32'h0000_0000);
        access("lw_f3_111", 1'b1, 1'b0, 3'b111, 9'h010, 32'h0);
        access("lw10c", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
        check("lw10c.value", RdData, 32'hDEAD_80EF);

        access("sw20_zero", 1'b0, 1'b1, 3'b010, 9'h020, 32'h0);
        @(negedge clk);
        MemWrite = 1'b1; Funct3 = 3'b010; Addr = 9'h020; WrData = 32'h1234_5678;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort.busy", 32'(Busy), 32'd0);
        check("abort.done", 32'(Done), 32'd0);
        check("abort.err", 32'(Err), 32'd0);
        check("abort.rddata", RdData, 32'h0);
        @(negedge clk);
        MemWrite = 1'b0;
        reset = 1'b0;
        exp_rd = 32'h0;
        access("abort_lw20", 1'b1, 1'b0, 3'b010, 9'h020, 32'h0);
        check("abort_lw20.value", RdData, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 32'h0;
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 9'h010;
        for (int c = 0; c < HOLD_W; c++) begin
            #1;
            if (Done) q2.push_back(c);
            if (done1) q1.push_back(c);
            if (done15) q15.push_back(c);
            @(negedge clk);
        end
        MemRead = 1'b0;
        repeat (20) @(negedge clk);
        check_hold("hold_l2", LAT, q2);
        check_hold("hold_l1", 1, q1);
        check_hold("hold_l15", 15, q15);
        exp_rd = ref_load(3'b010, 9'h010);
        check("hold.rddata", RdData, exp_rd);

        for (int n = 0; n < 80; n++) begin
            int       sel;
            logic     rd, wr;
            logic [8:0] a;
            sel = $urandom_range(0, 9);
            rd  = (sel <= 4);
            wr  = (sel == 0) || (sel >= 5);
            a   = 9'($urandom);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            access($sformatf("rand%0d", n), rd, wr, 3'($urandom), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder on the load/store side of the single-cycle RISC-V core. It serves the MemRead/MemWrite requests that the main decoder raises for lw/sw-class instructions. It holds a word-organised storage array and performs byte/half/word accesses selected by funct3. It answers after a fixed wait latency and drives a combinational Busy stall so the pipeline freezes until the access completes.

## Interface
- DEPTH, 128: number of 32-bit words in the array (power of two).
- LATENCY, 2: wait cycles between acceptance and commit; legal range 1..15.
- ADDR_W, $clog2(DEPTH)+2: byte-address width (derived).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; one clock domain (clk) only.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Funct3  in  3  access size/sign (instruction bits 14:12).
- Addr  in  ADDR_W  byte address (ALU result).
- WrData  in  32  store data (rs2); low bits used for SB/SH.
- RdData  out  32  load result, sign/zero-extended; held until next successful load.
- Busy  out  1  stall request to pipeline (combinational).
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle error pulse, coincident with Done.

## Operation
- FSM states IDLE, WAIT, RESP; 4-bit wait counter.
- IDLE: if exactly one of MemRead/MemWrite is high, capture Addr, Funct3, WrData and the op, load counter with LATENCY-1, and go to WAIT. Both high: capture as a bad request, then proceed normally through WAIT and RESP with Err. Neither high: stay in IDLE.
- WAIT: decrement the counter; on the edge where it equals 0, go to RESP. That edge is the commit edge: the store writes the array, and the load registers RdData.
- RESP: Done=1, with Err as computed. Go to IDLE unconditionally. Requests present in RESP are ignored: they belong to the instruction being released.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Byte lane = Addr[1:0]; half lane = Addr[1]. LB and LH sign-extend; LBU and LHU zero-extend.
- Stores: 000 SB, 001 SH, 010 SW. Only the addressed byte lanes are written; other bytes of the word are preserved.
- Word index = Addr[ADDR_W-1:2]. The full range maps, so no out-of-range case exists.
- Error cases: reserved Funct3 (loads 011/110/111; stores 011/1xx), misaligned access (half with Addr[0]=1; word with Addr[1:0]≠0), or both requests high. On error there is no array write, RdData is unchanged, and Err=1 with Done in RESP.
- Array contents are not reset.

## Timing
- Busy = (IDLE && (MemRead || MemWrite)) || WAIT. It is low in RESP, so the pipeline advances at the end of the RESP cycle.
- A request seen in IDLE at cycle N produces Done at cycle N+LATENCY+1. Busy is high in cycles N..N+LATENCY. The earliest next acceptance is cycle N+LATENCY+2.
- A store is visible to a load accepted any time after RESP.
- Reset values: state IDLE, counter 0, RdData 32'h0, Done 0, Err 0. Busy is 0 while reset is asserted, regardless of requests.
- Reset asserted in WAIT before the commit edge: the access is aborted, with no array write and no Done. Reset in RESP: Done drops immediately; the already committed write remains.
- Requests are sampled only in IDLE. Input changes during WAIT are ignored because the captured copies are used.

## Test plan
- Reset, then SW Addr=0x10 WrData=0xDEADBEEF, then LW Addr=0x10 (LATENCY=2). Required:
  - store Busy high for 3 cycles;
  - Done in the 4th cycle;
  - after the load's Done, RdData=0xDEADBEEF.
- SB Addr=0x11 WrData=0x80, then LB 0x11 -> RdData=0xFFFFFF80. Then LBU 0x11 -> 0x00000080, LH 0x10 -> 0xFFFF80EF, LW 0x10 -> 0xDEAD80EF.
- Misaligned LW Addr=0x12 and SH Addr=0x13:
  - each gives Done and Err together;
  - RdData is unchanged;
  - a following LW 0x10 still returns 0xDEAD80EF.
- MemRead=MemWrite=1, and separately LW with Funct3=3'b111 -> Err with Done after LATENCY+1 cycles; no array change.
- Assert reset one cycle after accepting SW Addr=0x20 WrData=0x12345678:
  - all outputs go to 0 immediately;
  - after release, LW 0x20 does not return 0x12345678 (pre-write that word to 0 first).
- Back-to-back LW requests held on MemRead: exactly one Done per instruction; no re-acceptance in RESP; spacing is LATENCY+2 cycles. Repeat with LATENCY=1 and LATENCY=15.
